// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - fetch/data requester, translator and bus signals of mem_req_arbiter
interface mem_req_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic        inst_ready;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_we;
    logic [3:0]  data_wstrb;
    logic [31:0] data_vaddr;
    logic [31:0] data_wdata;
    logic        data_ready;
    logic        data_rvalid;
    logic [31:0] data_rdata;

    logic [31:0] trans_vaddr;
    logic [31:0] trans_paddr;
    logic        trans_uncached;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_uncached;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    // slave is the arbiter; master is the requesters, translator and bus together
    modport slave (
        input  inst_req, inst_vaddr,
        output inst_ready, inst_rvalid, inst_rdata,
        input  data_req, data_we, data_wstrb, data_vaddr, data_wdata,
        output data_ready, data_rvalid, data_rdata,
        output trans_vaddr,
        input  trans_paddr, trans_uncached,
        output bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, bus_uncached,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output inst_req, inst_vaddr,
        input  inst_ready, inst_rvalid, inst_rdata,
        output data_req, data_we, data_wstrb, data_vaddr, data_wdata,
        input  data_ready, data_rvalid, data_rdata,
        input  trans_vaddr,
        output trans_paddr, trans_uncached,
        input  bus_req, bus_we, bus_wstrb, bus_addr, bus_wdata, bus_uncached,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - single-outstanding fetch/data arbiter with starvation guard toward one memory bus
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_arbiter_if.slave  io
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, TRANS, ADDR, DATA} state_t;

    state_t        r_state;
    logic [CW-1:0] r_starve_cnt;
    logic          r_owner;          // 1 = data requester owns the transaction
    logic [31:0]   r_vaddr;
    logic          r_we;
    logic [3:0]    r_wstrb;
    logic [31:0]   r_wdata;
    logic [31:0]   r_bus_addr;
    logic          r_bus_uncached;
    logic          r_bus_req;
    logic          r_inst_ready;
    logic          r_data_ready;
    logic          r_inst_rvalid;
    logic          r_data_rvalid;
    logic [31:0]   r_inst_rdata;
    logic [31:0]   r_data_rdata;

    logic          w_grant_inst;

    assign w_grant_inst = io.inst_req && (!io.data_req || (r_starve_cnt >= LIMIT));

    // ready is raised in IDLE; the request is latched on the edge that sees ready high
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_starve_cnt   <= '0;
            r_owner        <= 1'b0;
            r_vaddr        <= '0;
            r_we           <= 1'b0;
            r_wstrb        <= '0;
            r_wdata        <= '0;
            r_bus_addr     <= '0;
            r_bus_uncached <= 1'b0;
            r_bus_req      <= 1'b0;
            r_inst_ready   <= 1'b0;
            r_data_ready   <= 1'b0;
            r_inst_rvalid  <= 1'b0;
            r_data_rvalid  <= 1'b0;
            r_inst_rdata   <= '0;
            r_data_rdata   <= '0;
        end else begin
            r_inst_ready  <= 1'b0;
            r_data_ready  <= 1'b0;
            r_inst_rvalid <= 1'b0;
            r_data_rvalid <= 1'b0;
            if (!io.inst_req) begin
                r_starve_cnt <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (r_inst_ready || r_data_ready) begin
                        r_owner <= r_data_ready;
                        if (r_data_ready) begin
                            r_vaddr <= io.data_vaddr;
                            r_we    <= io.data_we;
                            r_wstrb <= io.data_wstrb;
                            r_wdata <= io.data_wdata;
                        end else begin
                            r_vaddr <= io.inst_vaddr;
                            r_we    <= 1'b0;
                            r_wstrb <= '0;
                            r_wdata <= '0;
                        end
                        r_state <= TRANS;
                    end else if (w_grant_inst) begin
                        r_inst_ready <= 1'b1;
                        r_starve_cnt <= '0;
                    end else if (io.data_req) begin
                        r_data_ready <= 1'b1;
                        if (io.inst_req && (r_starve_cnt < LIMIT)) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                TRANS: begin
                    r_bus_addr     <= io.trans_paddr;
                    r_bus_uncached <= io.trans_uncached;
                    r_bus_req      <= 1'b1;
                    r_state        <= ADDR;
                end
                ADDR: begin
                    if (io.bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (io.bus_data_ok) begin
                        if (r_owner) begin
                            r_data_rdata  <= io.bus_rdata;
                            r_data_rvalid <= 1'b1;
                        end else begin
                            r_inst_rdata  <= io.bus_rdata;
                            r_inst_rvalid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io.inst_ready   = r_inst_ready;
    assign io.inst_rvalid  = r_inst_rvalid;
    assign io.inst_rdata   = r_inst_rdata;
    assign io.data_ready   = r_data_ready;
    assign io.data_rvalid  = r_data_rvalid;
    assign io.data_rdata   = r_data_rdata;
    assign io.trans_vaddr  = r_vaddr;
    assign io.bus_req      = r_bus_req;
    assign io.bus_we       = r_we;
    assign io.bus_wstrb    = r_wstrb;
    assign io.bus_addr     = r_bus_addr;
    assign io.bus_wdata    = r_wdata;
    assign io.bus_uncached = r_bus_uncached;
endmodule
